// File: rtl/weighting_matrix_pkg.sv
// Shared definitions for the weighting-matrix weight sink: FSM state encoding
// and helpers that derive the buffer size N and address width AW.
package weighting_matrix_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StDone
   } state_e;

   // Total number of buffered weights (rows * row length).
   function automatic int unsigned calc_n(input int unsigned num_channels,
                                          input int unsigned num_output_channels);
      return num_channels * num_output_channels;
   endfunction

   // Address width for N entries; never below 1 so ports stay legal.
   function automatic int unsigned calc_aw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/w_sink_ram.sv
// Simple dual-port weight buffer: one write port, one registered read port.
// No reset on the array or the read register; out-of-range reads return 0.
module w_sink_ram #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 384,
   parameter int unsigned AW    = 9
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   // Array write; the writer only ever presents in-range addresses.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data is sampled before this edge's write lands, so a same-address
   // read-during-write returns the old contents. Holds when not reading.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = ({1'b0, raddr_i} < DepthW) ? mem_q[raddr_i] : '0;
      end
   end

   // Read output register.
   always_ff @(posedge clk_i) begin
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/weighting_matrix_w_axis_sink.sv
// AXI-stream sink that captures one N-entry weight matrix (row-major) into a
// local buffer and exposes a registered random-access read port.
// Optional protocol checking of axis_w_last: define W_SINK_PROTOCOL_CHECK_EN.
module weighting_matrix_w_axis_sink
   import weighting_matrix_pkg::*;
#(
   parameter int unsigned WIDTH               = 32,
   parameter int unsigned NUM_CHANNELS        = 128,
   parameter int unsigned NUM_OUTPUT_CHANNELS = 3,
   localparam int unsigned N  = calc_n(NUM_CHANNELS, NUM_OUTPUT_CHANNELS),
   localparam int unsigned AW = calc_aw(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] axis_w_data,
   input  logic             axis_w_valid,
   input  logic             axis_w_last,
   output logic             axis_w_ready,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      beat_count,
   output logic             err_early_last,
   output logic             err_missing_last
);

   localparam logic [AW:0] LastBeat = (AW+1)'(N - 1);
   localparam logic [AW:0] OneBeat  = (AW+1)'(1);

   state_e           state_q, state_d;
   logic [AW:0]      beat_count_q, beat_count_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_seen_q, rd_seen_d;
   logic             accept;
   logic             arm;
   logic             is_last_beat;
   logic             early_end;
   logic [WIDTH-1:0] ram_rdata;

   assign axis_w_ready = (state_q == StRecv);
   assign busy         = (state_q == StRecv);
   assign done         = (state_q == StDone);
   assign accept       = axis_w_valid & axis_w_ready;
   assign arm          = start & (state_q != StRecv);
   assign is_last_beat = (beat_count_q == LastBeat);

`ifdef W_SINK_PROTOCOL_CHECK_EN
   logic err_early_q, err_early_d;
   logic err_missing_q, err_missing_d;

   // A last flag before the final beat terminates the frame early.
   assign early_end = axis_w_last & ~is_last_beat;

   // Sticky protocol flags, cleared when a new frame is armed.
   always_comb begin
      err_early_d   = err_early_q;
      err_missing_d = err_missing_q;
      if (arm) begin
         err_early_d   = 1'b0;
         err_missing_d = 1'b0;
      end else if (accept) begin
         if (early_end) begin
            err_early_d = 1'b1;
         end
         if (is_last_beat && !axis_w_last) begin
            err_missing_d = 1'b1;
         end
      end
   end

   // Protocol flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_early_q   <= 1'b0;
         err_missing_q <= 1'b0;
      end else begin
         err_early_q   <= err_early_d;
         err_missing_q <= err_missing_d;
      end
   end

   assign err_early_last   = err_early_q;
   assign err_missing_last = err_missing_q;
`else
   // Completion is by beat count alone; last is not observed.
   logic unused_last;
   assign unused_last      = axis_w_last;
   assign early_end        = 1'b0;
   assign err_early_last   = 1'b0;
   assign err_missing_last = 1'b0;
`endif

   // Frame FSM and beat counter next-state.
   always_comb begin
      state_d      = state_q;
      beat_count_d = beat_count_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StRecv;
               beat_count_d = '0;
            end
         end
         StRecv: begin
            if (accept) begin
               beat_count_d = beat_count_q + OneBeat;
               if (is_last_beat || early_end) begin
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Read-port status: rd_valid pulses after each read; rd_seen masks the
   // unreset RAM output until a read has actually been performed.
   always_comb begin
      rd_valid_d = rd_en;
      rd_seen_d  = rd_seen_q | rd_en;
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         beat_count_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_seen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_count_q <= beat_count_d;
         rd_valid_q   <= rd_valid_d;
         rd_seen_q    <= rd_seen_d;
      end
   end

   w_sink_ram #(
      .WIDTH (WIDTH),
      .DEPTH (N),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (accept),
      .waddr_i (beat_count_q[AW-1:0]),
      .wdata_i (axis_w_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   assign beat_count = beat_count_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_seen_q ? ram_rdata : '0;

endmodule
